// File: rtl/lfsr_generator_if.sv
// Handshake and status bundle between the LFSR word generator and its consumer.
// master = generator side, slave = controller/consumer side.
interface lfsr_generator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] count;
    logic             inject_err;
    logic             ready;
    logic             dv_out;
    logic [WIDTH-1:0] dataout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] words_sent;

    modport master (
        input  start, stop, seed, count, inject_err, ready,
        output dv_out, dataout, busy, done, words_sent
    );

    modport slave (
        output start, stop, seed, count, inject_err, ready,
        input  dv_out, dataout, busy, done, words_sent
    );
endinterface

// File: rtl/lfsr_generator.sv
// Combinational Galois LFSR step: multiply by x modulo x^32+x^22+x^2+x+1.
// Latency: none (pure logic).
// Backpressure: not applicable.
module lfsr_next_word #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h0040_0007
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);
    always_comb begin
        nxt = {cur[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{cur[WIDTH-1]}});
    end
endmodule

// Emits a run of LFSR words over a valid/ready port, optional length, stop and single-word error injection.
// Latency: first word valid one cycle after an accepted start; one word per cycle under continuous ready.
// Backpressure: ready low holds dv_out/dataout stable until the word is taken.
module lfsr_generator #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_generator_if.master   gen
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] words_sent_q;
    logic [WIDTH-1:0] dataout_q;
    logic [WIDTH-1:0] first_word;
    logic             dv_out_q;
    logic             stop_q;
    logic             err_q;
    logic             xfer;
    logic             last_xfer;
    logic             err_consume;

    lfsr_next_word #(.WIDTH(WIDTH)) u_step (
        .cur (lfsr_q),
        .nxt (lfsr_next)
    );

    always_comb begin
        first_word  = (gen.seed == '0) ? DEFAULT_SEED : gen.seed;
        xfer        = (state_q == RUN) && dv_out_q && gen.ready;
        last_xfer   = xfer && (stop_q || gen.stop ||
                               ((count_q != '0) && (words_sent_q + 1'b1 == count_q)));
        // A pending error is spent only when a fresh word is actually loaded.
        err_consume = xfer && !last_xfer && err_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gen.start) state_d = RUN;
            RUN:     if (last_xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= '0;
            count_q      <= '0;
            words_sent_q <= '0;
            dataout_q    <= '0;
            dv_out_q     <= 1'b0;
            stop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= err_q ? !err_consume : gen.inject_err;
            case (state_q)
                IDLE: begin
                    if (gen.start) begin
                        count_q      <= gen.count;
                        lfsr_q       <= first_word;
                        dataout_q    <= first_word;
                        dv_out_q     <= 1'b1;
                        words_sent_q <= '0;
                        stop_q       <= 1'b0;
                    end
                end
                RUN: begin
                    if (gen.stop) stop_q <= 1'b1;
                    if (xfer) begin
                        words_sent_q <= words_sent_q + 1'b1;
                        if (last_xfer) begin
                            dv_out_q <= 1'b0;
                        end else begin
                            // Corruption touches only the presented copy, never the LFSR state.
                            lfsr_q    <= lfsr_next;
                            dataout_q <= lfsr_next ^ {{(WIDTH-1){1'b0}}, err_q};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gen.dv_out     = dv_out_q;
    assign gen.dataout    = dataout_q;
    assign gen.words_sent = words_sent_q;
    assign gen.busy       = (state_q == RUN);
    assign gen.done       = (state_q == DONE);
endmodule

// File: tb/tb_lfsr_generator.sv
// Scoreboard bench for lfsr_generator: driver predicts every transferred word from a GF(2)
// polynomial model and queues it; an independent monitor pops and compares on each dv_out&ready.
`timescale 1ns/1ps
module tb_lfsr_generator;
    logic clk;
    logic reset;

    lfsr_generator_if bus ();

    lfsr_generator dut (
        .clk   (clk),
        .reset (reset),
        .gen   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    bit          err_carry = 1'b0;

    // Multiply by x in GF(2)[x] and reduce modulo p(x) = x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] gf_next(input logic [31:0] x);
        logic [32:0] t;
        t = {x, 1'b0};
        if (t[32]) t = t ^ 33'h1_0040_0007;
        return t[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.dv_out === 1'b1 && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h expected no transfer", bus.dataout);
            end else begin
                check("dataout", bus.dataout, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.start = 0; bus.stop = 0; bus.inject_err = 0; bus.ready = 0;
        bus.seed = 0;  bus.count = 0;
    endtask

    task automatic run_words(input logic [31:0] sd, input logic [31:0] cnt, input int nstop,
                             input bit stop_rdy, input int stall_pct, input int inj_at);
        logic [31:0] cur;
        logic [31:0] exp_word;
        int sent, nwords, err_target, cycles;
        bit stop_done, inj_done, rdy;
        nwords = int'(cnt);
        if (nstop > 0 && (cnt == 0 || nstop < int'(cnt))) nwords = nstop;
        err_target = err_carry ? 1 : -1;
        err_carry  = 1'b0;
        cur = (sd == 0) ? 32'h0000_0001 : sd;
        sent = 0; stop_done = 0; inj_done = 0; cycles = 0;
        bus.start = 1; bus.seed = sd; bus.count = cnt; bus.ready = 1'($urandom_range(1));
        @(posedge clk); #1;
        bus.start = 0;
        while (sent < nwords && cycles < 20000) begin
            rdy = ($urandom_range(99) >= stall_pct);
            bus.start = 1'($urandom_range(1)); bus.seed = $urandom; bus.count = $urandom;
            bus.stop = 0; bus.inject_err = 0;
            if (nstop > 0 && sent == nstop - 1 && !stop_done) begin
                bus.stop = 1; rdy = stop_rdy; stop_done = 1;
            end
            if (sent == inj_at && !inj_done) begin
                bus.inject_err = 1; inj_done = 1;
                if (!(err_carry || err_target > sent)) begin
                    err_target = rdy ? sent + 2 : sent + 1;
                    if (err_target >= nwords) begin err_carry = 1; err_target = -1; end
                end
            end
            bus.ready = rdy;
            exp_word = cur ^ ((sent == err_target) ? 32'h1 : 32'h0);
            if (rdy) exp_q.push_back(exp_word);
            @(negedge clk);
            check("busy_in_run", {31'b0, bus.busy}, 32'h1);
            check("dv_out_in_run", {31'b0, bus.dv_out}, 32'h1);
            if (!rdy) check("dataout_hold", bus.dataout, exp_word);
            if (rdy) begin sent++; cur = gf_next(cur); end
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 20000) begin
            n_checks++;
            $display("FAIL run_budget: got %0d words expected %0d", sent, nwords);
        end
        // DONE cycle: a start here must be ignored.
        bus.start = 1; bus.stop = 0; bus.inject_err = 0; bus.ready = 1'($urandom_range(1));
        @(negedge clk);
        check("done_pulse", {31'b0, bus.done}, 32'h1);
        check("busy_in_done", {31'b0, bus.busy}, 32'h0);
        check("dv_out_in_done", {31'b0, bus.dv_out}, 32'h0);
        check("words_sent", bus.words_sent, 32'(nwords));
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
        bus.start = 0;
        @(negedge clk);
        check("done_single", {31'b0, bus.done}, 32'h0);
        check("idle_after_done", {31'b0, bus.busy}, 32'h0);
        check("words_sent_hold", bus.words_sent, 32'(nwords));
    endtask

    task automatic inject_idle();
        bus.inject_err = 1;
        @(posedge clk); #1;
        bus.inject_err = 0;
        err_carry = 1'b1;
    endtask

    initial begin
        logic [31:0] cur;
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_dv_out", {31'b0, bus.dv_out}, 32'h0);
        check("rst_dataout", bus.dataout, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_words_sent", bus.words_sent, 32'h0);

        run_words(32'h0000_0001, 32'd4, 0, 1'b0, 0, -1);
        run_words(32'h0000_0000, 32'd2, 0, 1'b0, 0, -1);
        run_words($urandom, 32'd3, 0, 1'b0, 60, -1);
        run_words($urandom, 32'd0, 5, 1'b0, 30, -1);
        run_words($urandom, 32'd3, 3, 1'b1, 0, -1);
        run_words($urandom, 32'd0, 1000, 1'b0, 20, 500);
        inject_idle();
        run_words($urandom, 32'd4, 0, 1'b0, 25, -1);
        for (int r = 0; r < 6; r++)
            run_words($urandom, 32'($urandom_range(8, 1)), 0, 1'b0, 30, -1);

        // Reset partway through a count=10 run.
        cur = $urandom;
        if (cur == 0) cur = 32'h1;
        bus.start = 1; bus.seed = cur; bus.count = 32'd10;
        @(posedge clk); #1;
        bus.start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.ready = 1;
            exp_q.push_back(cur);
            @(negedge clk);
            @(posedge clk); #1;
            cur = gf_next(cur);
        end
        bus.ready = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        err_carry = 1'b0;
        @(negedge clk);
        check("midrun_rst_dv_out", {31'b0, bus.dv_out}, 32'h0);
        check("midrun_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("midrun_rst_words", bus.words_sent, 32'h0);
        check("midrun_rst_dataout", bus.dataout, 32'h0);
        check("midrun_rst_queue", 32'(exp_q.size()), 32'h0);
        run_words($urandom, 32'd3, 0, 1'b0, 20, -1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lfsr_generator.md
LFSR_GENERATOR -- requirements
Module: lfsr_generator

Interface
REQ-001 Parameter: WIDTH, 32, word width of generated data (only 32 supported).
REQ-002 Parameter: DEFAULT_SEED, 32'h0000_0001, substitute seed used when seed input is zero.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin a run; sampled only in IDLE.
REQ-006 Port: stop  input  1  request early end of run; sampled in RUN.
REQ-007 Port: seed  input  32  first word of the run; captured on accepted start.
REQ-008 Port: count  input  32  words per run, captured on accepted start; 0 = unlimited.
REQ-009 Port: inject_err  input  1  pulse; corrupt one future word.
REQ-010 Port: ready  input  1  downstream accepts dataout this cycle.
REQ-011 Port: dv_out  output  1  dataout valid.
REQ-012 Port: dataout  output  32  generated LFSR word.
REQ-013 Port: busy  output  1  high in RUN.
REQ-014 Port: done  output  1  one-cycle pulse at run end.
REQ-015 Port: words_sent  output  32  transfers completed in current/last run.

Function
REQ-016 Next-word function SHALL be the codebase lfsr block, WIDTH 32, instantiated combinationally: next(x); sequence matches what the codebase checker expects (word N+1 = next(word N)).
REQ-017 FSM states SHALL be IDLE, RUN, DONE; only these.
REQ-018 IDLE + start: capture count; state <= (seed==0 ? DEFAULT_SEED : seed); words_sent <= 0; go RUN; dv_out=1 with dataout=state the following cycle (start-to-first-valid latency 1 cycle).
REQ-019 Transfer SHALL occur on any cycle with dv_out=1 and ready=1.
REQ-020 On transfer: words_sent += 1; state <= next(state); dataout presents new state next cycle (zero bubble under continuous ready).
REQ-021 With dv_out=1 and ready=0, dataout and dv_out SHALL hold stable; dv_out never deasserts before transfer except on reset.
REQ-022 count!=0: transfer making words_sent==count SHALL move to DONE; dv_out=0 next cycle.
REQ-023 count==0: RUN continues indefinitely; words_sent wraps 0xFFFF_FFFF -> 0.
REQ-024 stop in RUN SHALL be latched; run ends at next transfer (pending word always delivered); stop coincident with transfer ends run at that transfer.
REQ-025 count reached and stop in same cycle: single DONE, single done pulse.
REQ-026 DONE lasts exactly one cycle with done=1, busy=0, then IDLE; words_sent holds until next start.
REQ-027 inject_err pulse SHALL set a pending flag; next word loaded to dataout (not one already presented) is XORed with 32'h0000_0001; flag clears; LFSR state stays uncorrupted, so exactly one word mismatches.
REQ-028 inject_err while flag pending: no additional effect; inject_err in IDLE stays pending into next run's second word.
REQ-029 start in RUN/DONE SHALL be ignored.

Reset
REQ-030 On reset: state IDLE; dv_out=0, dataout=0, busy=0, done=0, words_sent=0, stop latch and inject flag cleared; takes effect next edge including mid-run, no further words emitted.

Verification
REQ-031 seed=0x0000_0001, count=4, ready=1: dataout = 0x1, next(0x1), next^2(0x1), next^3(0x1) on 4 consecutive cycles; done pulse cycle after 4th; words_sent=4.
REQ-032 seed=0, count=2: first word = 0x0000_0001 (DEFAULT_SEED).
REQ-033 count=3, ready low 3 cycles during word 2: dataout/dv_out stable all 3 cycles; words_sent=3 at end; no word skipped/duplicated.
REQ-034 Loopback to codebase lfsr checker (dv_in=dv_out&ready), count=0, 1000 words: error stays 0; inject_err once: error rises 1 and stays.
REQ-035 count=0, stop asserted with ready=0 on word 5: word 5 delivered when ready returns, then done; words_sent=5.
REQ-036 reset at word 3 of count=10 run: next cycle dv_out=0, busy=0, words_sent=0; new start works normally.
